cdc_fifo: RTL and testbench

CDC_FIFO -- requirements
Module: cdc_fifo

---
 rtl/cdc_fifo.sv | 158 +++++++++++++++
 tb/tb_cdc_fifo.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo.sv
// cdc_fifo: dual-clock first-word-fall-through FIFO.
//
// Write and read pointers are binary, ADDR_W+1 bits wide, with the extra MSB
// distinguishing full from empty. Each side registers the Gray form of its
// pointer. The other side passes that value through a SYNC_STAGES-deep
// synchronizer and converts it back to binary. Only Gray values cross between
// clocks, so a synchronized pointer is either the old value or the new one.
// As a result, flags can only lag in the safe direction.
//
// Ports
//   w_clk, w_rst       write clock, synchronous active-high reset
//   r_clk, r_rst       read clock, synchronous active-high reset
//   w_push, w_data     write request and payload
//   w_full             no free entry as seen from the write side
//   w_almost_full      w_count >= AF_LEVEL
//   w_count            write-side fill level (may overstate)
//   w_overflow         sticky, a push was attempted while full
//   r_pop              read acknowledge for the head entry
//   r_data             head entry, valid whenever r_empty is low
//   r_empty            no valid entry as seen from the read side
//   r_almost_empty     r_count <= AE_LEVEL
//   r_count            read-side fill level (may understate)
//   r_underflow        sticky, a pop was attempted while empty
`timescale 1ns/1ps
module cdc_fifo #(
    parameter int DATA_W      = 37,
    parameter int ADDR_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = (1 << ADDR_W) - 1,
    parameter int AE_LEVEL    = 1
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              w_push,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_full,
    output logic              w_almost_full,
    output logic [ADDR_W:0]   w_count,
    output logic              w_overflow,
    input  logic              r_pop,
    output logic [DATA_W-1:0] r_data,
    output logic              r_empty,
    output logic              r_almost_empty,
    output logic [ADDR_W:0]   r_count,
    output logic              r_underflow
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0] AF_LVL  = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_LVL  = (ADDR_W+1)'(AE_LEVEL);

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write domain state
    logic [ADDR_W:0]                   wptr_q, wptr_d;
    logic [ADDR_W:0]                   wgray_q, wgray_d;
    logic [SYNC_STAGES-1:0][ADDR_W:0]  r2w_sync_q, r2w_sync_d;
    logic                              w_overflow_q, w_overflow_d;
    logic [ADDR_W:0]                   w_rptr_bin;
    logic                              w_push_ok;

    // Read domain state
    logic [ADDR_W:0]                   rptr_q, rptr_d;
    logic [ADDR_W:0]                   rgray_q, rgray_d;
    logic [SYNC_STAGES-1:0][ADDR_W:0]  w2r_sync_q, w2r_sync_d;
    logic                              r_underflow_q, r_underflow_d;
    logic [ADDR_W:0]                   r_wptr_bin;
    logic                              r_pop_ok;

    // Write side: flags come from the local pointer and the synchronized read
    // pointer. The Gray register is loaded from the next pointer, so a push
    // starts crossing at the same edge that accepts it.
    always_comb begin
        w_rptr_bin    = gray2bin(r2w_sync_q[SYNC_STAGES-1]);
        w_full        = (wptr_q[ADDR_W] != w_rptr_bin[ADDR_W]) &&
                        (wptr_q[ADDR_W-1:0] == w_rptr_bin[ADDR_W-1:0]);
        w_count       = wptr_q - w_rptr_bin;
        w_almost_full = (w_count >= AF_LVL);
        w_push_ok     = w_push && !w_full;
        wptr_d        = w_push_ok ? (wptr_q + PTR_ONE) : wptr_q;
        wgray_d       = bin2gray(wptr_d);
        // Index 0 captures the foreign Gray value and the top index is used.
        r2w_sync_d    = {r2w_sync_q[SYNC_STAGES-2:0], rgray_q};
        w_overflow_d  = w_overflow_q || (w_push && w_full);
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            wptr_q       <= '0;
            wgray_q      <= '0;
            r2w_sync_q   <= '0;
            w_overflow_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            wgray_q      <= wgray_d;
            r2w_sync_q   <= r2w_sync_d;
            w_overflow_q <= w_overflow_d;
        end
    end

    // Storage is never reset. A slot is written only when the write side
    // knows it is free.
    always_ff @(posedge w_clk) begin
        if (!w_rst && w_push_ok) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= w_data;
        end
    end

    assign w_overflow = w_overflow_q;

    // Read side mirrors the write side. The head entry is presented directly
    // from memory, so data is ready as soon as r_empty drops.
    always_comb begin
        r_wptr_bin     = gray2bin(w2r_sync_q[SYNC_STAGES-1]);
        r_empty        = (rptr_q == r_wptr_bin);
        r_count        = r_wptr_bin - rptr_q;
        r_almost_empty = (r_count <= AE_LVL);
        r_pop_ok       = r_pop && !r_empty;
        rptr_d         = r_pop_ok ? (rptr_q + PTR_ONE) : rptr_q;
        rgray_d        = bin2gray(rptr_d);
        w2r_sync_d     = {w2r_sync_q[SYNC_STAGES-2:0], wgray_q};
        r_underflow_d  = r_underflow_q || (r_pop && r_empty);
        r_data         = mem_q[rptr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            rptr_q        <= '0;
            rgray_q       <= '0;
            w2r_sync_q    <= '0;
            r_underflow_q <= 1'b0;
        end else begin
            rptr_q        <= rptr_d;
            rgray_q       <= rgray_d;
            w2r_sync_q    <= w2r_sync_d;
            r_underflow_q <= r_underflow_d;
        end
    end

    assign r_underflow = r_underflow_q;

endmodule

// File: tb/tb_cdc_fifo.sv
// tb_cdc_fifo: testbench for cdc_fifo.
// Instance A uses the default parameters. Instance B uses DEPTH=8 with
// AF_LEVEL=6 and AE_LEVEL=2. Expected words are queued when a push is
// issued. Monitors on the falling edge of r_clk pop and compare each word
// the DUT is about to hand over.
`timescale 1ns/1ps
module tb_cdc_fifo;

    localparam int DW = 37;
    localparam int AW = 2;
    localparam int SS = 2;

    logic          w_clk = 1'b0;
    logic          r_clk = 1'b0;
    logic          w_rst, r_rst;
    logic          w_push, r_pop;
    logic [DW-1:0] w_data, r_data;
    logic          w_full, w_almost_full, w_overflow;
    logic          r_empty, r_almost_empty, r_underflow;
    logic [AW:0]   w_count, r_count;

    logic          b_w_push, b_r_pop;
    logic [7:0]    b_w_data, b_r_data;
    logic          b_w_full, b_w_almost_full, b_w_overflow;
    logic          b_r_empty, b_r_almost_empty, b_r_underflow;
    logic [3:0]    b_w_count, b_r_count;

    int            checks = 0;
    int            errors = 0;
    int            pops_a = 0;
    int            n;
    logic [DW-1:0] exp_a[$];
    logic [7:0]    exp_b[$];

    cdc_fifo #(.DATA_W(DW), .ADDR_W(AW), .SYNC_STAGES(SS)) dut_a (
        .w_clk(w_clk), .w_rst(w_rst), .r_clk(r_clk), .r_rst(r_rst),
        .w_push(w_push), .w_data(w_data), .w_full(w_full),
        .w_almost_full(w_almost_full), .w_count(w_count), .w_overflow(w_overflow),
        .r_pop(r_pop), .r_data(r_data), .r_empty(r_empty),
        .r_almost_empty(r_almost_empty), .r_count(r_count), .r_underflow(r_underflow)
    );

    cdc_fifo #(.DATA_W(8), .ADDR_W(3), .SYNC_STAGES(SS), .AF_LEVEL(6), .AE_LEVEL(2)) dut_b (
        .w_clk(w_clk), .w_rst(w_rst), .r_clk(r_clk), .r_rst(r_rst),
        .w_push(b_w_push), .w_data(b_w_data), .w_full(b_w_full),
        .w_almost_full(b_w_almost_full), .w_count(b_w_count), .w_overflow(b_w_overflow),
        .r_pop(b_r_pop), .r_data(b_r_data), .r_empty(b_r_empty),
        .r_almost_empty(b_r_almost_empty), .r_count(b_r_count), .r_underflow(b_r_underflow)
    );

    // Write clock is three times faster than the read clock. The phase
    // offset keeps the two edges from ever coinciding.
    initial forever #5 w_clk = ~w_clk;
    initial begin
        #2;
        forever #15 r_clk = ~r_clk;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Push one word into A. Only words the bench expects to be accepted go
    // into the scoreboard.
    task automatic applyStimulus(input logic [DW-1:0] data, input bit accept);
        w_push = 1'b1;
        w_data = data;
        if (accept) exp_a.push_back(data);
        @(posedge w_clk);
        #1;
        w_push = 1'b0;
    endtask

    task automatic applyStimulusB(input logic [7:0] data);
        b_w_push = 1'b1;
        b_w_data = data;
        exp_b.push_back(data);
        @(posedge w_clk);
        #1;
        b_w_push = 1'b0;
    endtask

    // Align to the read clock first so a monitor always sees the pop request
    // on the falling edge before the popping edge.
    task automatic popA();
        @(posedge r_clk);
        #1;
        r_pop = 1'b1;
        @(posedge r_clk);
        #1;
        r_pop = 1'b0;
    endtask

    task automatic popB();
        @(posedge r_clk);
        #1;
        b_r_pop = 1'b1;
        @(posedge r_clk);
        #1;
        b_r_pop = 1'b0;
    endtask

    task automatic resetAll();
        w_rst    = 1'b1;
        r_rst    = 1'b1;
        w_push   = 1'b0;
        r_pop    = 1'b0;
        w_data   = '0;
        b_w_push = 1'b0;
        b_r_pop  = 1'b0;
        b_w_data = '0;
        repeat (4) @(posedge r_clk);
        #1;
        w_rst = 1'b0;
        r_rst = 1'b0;
        exp_a.delete();
        exp_b.delete();
        @(posedge w_clk);
        #1;
    endtask

    // Monitors: a word leaves the FIFO at the next r_clk rise whenever pop is
    // requested and the read side is not empty.
    always @(negedge r_clk) begin
        if (!r_rst && r_pop && !r_empty) begin
            pops_a++;
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL a_data_extra actual=%0h expected=none", r_data);
            end else begin
                checkOutput("a_data", r_data, exp_a.pop_front());
            end
        end
    end

    always @(negedge r_clk) begin
        if (!r_rst && b_r_pop && !b_r_empty) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL b_data_extra actual=%0h expected=none", b_r_data);
            end else begin
                checkOutput("b_data", b_r_data, exp_b.pop_front());
            end
        end
    end

    initial begin
        resetAll();
        $display("[TB] reset state");
        checkOutput("rst_r_empty", r_empty, 1);
        checkOutput("rst_w_full", w_full, 0);
        checkOutput("rst_w_count", w_count, 0);
        checkOutput("rst_r_count", r_count, 0);
        checkOutput("rst_w_overflow", w_overflow, 0);
        checkOutput("rst_r_underflow", r_underflow, 0);
        checkOutput("rst_r_almost_empty", r_almost_empty, 1);
        checkOutput("rst_w_almost_full", w_almost_full, 0);

        $display("[TB] single push latency");
        applyStimulus(DW'(37'hA1), 1'b1);
        checkOutput("lat_empty_at_push", r_empty, 1);
        @(posedge r_clk);
        #1;
        checkOutput("lat_empty_one_edge", r_empty, 1);
        n = 1;
        while (r_empty && n < SS + 2) begin
            @(posedge r_clk);
            #1;
            n++;
        end
        checkOutput("lat_visible", r_empty, 0);
        checkOutput("lat_data", r_data, 64'hA1);
        checkOutput("lat_r_count", r_count, 1);
        popA();
        n = 0;
        while (w_count != 0 && n < SS + 2) begin
            @(posedge w_clk);
            #1;
            n++;
        end
        checkOutput("pop_seen_w_count", w_count, 0);

        $display("[TB] fill and overflow");
        for (int i = 1; i <= 4; i++) applyStimulus(DW'(i), 1'b1);
        checkOutput("fill_w_full", w_full, 1);
        checkOutput("fill_w_count", w_count, 4);
        checkOutput("fill_w_almost_full", w_almost_full, 1);
        applyStimulus(DW'(5), 1'b0);
        checkOutput("fill_w_overflow", w_overflow, 1);
        checkOutput("fill_w_count_after_drop", w_count, 4);
        n = 0;
        while (r_count != 4 && n < 2 * (SS + 2)) begin
            @(posedge r_clk);
            #1;
            n++;
        end
        checkOutput("fill_r_count", r_count, 4);
        repeat (4) popA();
        checkOutput("drain_r_empty", r_empty, 1);
        checkOutput("drain_sb_empty", exp_a.size(), 0);
        checkOutput("drain_w_overflow_sticky", w_overflow, 1);

        $display("[TB] underflow");
        @(posedge r_clk);
        #1;
        r_pop = 1'b1;
        @(posedge r_clk);
        #1;
        r_pop = 1'b0;
        checkOutput("uf_r_underflow", r_underflow, 1);
        checkOutput("uf_r_count", r_count, 0);
        checkOutput("uf_r_empty", r_empty, 1);
        applyStimulus(DW'(37'h77), 1'b1);
        n = 0;
        while (r_empty && n < 2 * (SS + 2)) begin
            @(posedge r_clk);
            #1;
            n++;
        end
        checkOutput("uf_next_visible", r_empty, 0);
        popA();
        checkOutput("uf_sb_empty", exp_a.size(), 0);
        resetAll();
        checkOutput("uf_cleared", r_underflow, 0);
        checkOutput("of_cleared", w_overflow, 0);

        $display("[TB] random stream of 100 words");
        pops_a = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    int g;
                    g = 0;
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge w_clk);
                        #1;
                    end
                    while (w_full && g < 2000) begin
                        @(posedge w_clk);
                        #1;
                        g++;
                    end
                    applyStimulus(DW'(i + 256), 1'b1);
                end
            end
            begin
                int c;
                c = 0;
                while (pops_a < 100 && c < 3000) begin
                    @(posedge r_clk);
                    #1;
                    r_pop = !r_empty && ($urandom_range(0, 3) != 0);
                    c++;
                end
                r_pop = 1'b0;
            end
        join
        checkOutput("stream_pop_count", pops_a, 100);
        checkOutput("stream_sb_empty", exp_a.size(), 0);
        checkOutput("stream_no_overflow", w_overflow, 0);
        checkOutput("stream_no_underflow", r_underflow, 0);

        $display("[TB] thresholds on depth-8 instance");
        resetAll();
        for (int i = 1; i <= 5; i++) applyStimulusB(8'(i * 3));
        checkOutput("b_af_at5", b_w_almost_full, 0);
        checkOutput("b_w_count5", b_w_count, 5);
        applyStimulusB(8'hC6);
        checkOutput("b_af_at6", b_w_almost_full, 1);
        checkOutput("b_w_count6", b_w_count, 6);
        checkOutput("b_w_full6", b_w_full, 0);
        n = 0;
        while (b_r_count != 6 && n < 2 * (SS + 2)) begin
            @(posedge r_clk);
            #1;
            n++;
        end
        checkOutput("b_r_count6", b_r_count, 6);
        checkOutput("b_ae_at6", b_r_almost_empty, 0);
        repeat (3) popB();
        checkOutput("b_r_count3", b_r_count, 3);
        checkOutput("b_ae_at3", b_r_almost_empty, 0);
        popB();
        checkOutput("b_r_count2", b_r_count, 2);
        checkOutput("b_ae_at2", b_r_almost_empty, 1);
        checkOutput("b_sb_left", exp_b.size(), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
